// File: rtl/pb_field_encoder.sv
// Registered protobuf field encoder: varint key plus wire-encoded value, 1-cycle latency.
// Optional macro SER_ZIGZAG_EN enables ZigZag encoding for SINT32/SINT64.
module pb_field_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [28:0] field_id,
  input  logic [4:0]  field_type,
  input  logic [63:0] value,
  output logic        out_valid,
  output logic [39:0] hdr_out,
  output logic [2:0]  hdr_len,
  output logic [79:0] val_out,
  output logic [3:0]  val_len,
  output logic        err
);

  typedef enum logic [4:0] {
    T_NONE     = 5'd0,
    T_DOUBLE   = 5'd1,
    T_FLOAT    = 5'd2,
    T_INT64    = 5'd3,
    T_UINT64   = 5'd4,
    T_INT32    = 5'd5,
    T_FIXED64  = 5'd6,
    T_FIXED32  = 5'd7,
    T_BOOL     = 5'd8,
    T_STRING   = 5'd9,
    T_GROUP    = 5'd10,
    T_MESSAGE  = 5'd11,
    T_BYTES    = 5'd12,
    T_UINT32   = 5'd13,
    T_ENUM     = 5'd14,
    T_SFIXED32 = 5'd15,
    T_SFIXED64 = 5'd16,
    T_SINT32   = 5'd17,
    T_SINT64   = 5'd18
  } ftype_e;

  logic [2:0]  wire_type;
  logic        is_varint;
  logic        bad_type;
  logic [63:0] operand;
  logic [79:0] fix_val;
  logic [3:0]  fix_len;
  logic [31:0] key_word;
  logic [31:0] kshift;
  logic [63:0] vshift;
  logic [39:0] hdr_c;
  logic [2:0]  hdr_len_c;
  logic [79:0] val_c;
  logic [3:0]  val_len_c;
  logic        entry_err;

  // Type decode: wire type plus either a varint operand or a raw fixed payload.
  always_comb begin
    wire_type = 3'd0;
    is_varint = 1'b1;
    bad_type  = 1'b0;
    operand   = '0;
    fix_val   = '0;
    fix_len   = '0;
    case (field_type)
      T_DOUBLE, T_FIXED64, T_SFIXED64: begin
        wire_type = 3'd1;
        is_varint = 1'b0;
        fix_val   = {16'd0, value};
        fix_len   = 4'd8;
      end
      T_FLOAT, T_FIXED32, T_SFIXED32: begin
        wire_type = 3'd5;
        is_varint = 1'b0;
        fix_val   = {48'd0, value[31:0]};
        fix_len   = 4'd4;
      end
      T_INT64, T_UINT64: operand = value;
      T_STRING, T_BYTES, T_MESSAGE: begin
        wire_type = 3'd2;
        operand   = value;
      end
      T_INT32, T_ENUM: operand = {{32{value[31]}}, value[31:0]};
      T_UINT32:        operand = {32'd0, value[31:0]};
      T_BOOL:          operand = {63'd0, value[0]};
      T_GROUP: begin
        wire_type = 3'd3;
        is_varint = 1'b0;
      end
`ifdef SER_ZIGZAG_EN
      T_SINT32: operand = {32'd0, {value[30:0], 1'b0} ^ {32{value[31]}}};
      T_SINT64: operand = {value[62:0], 1'b0} ^ {64{value[63]}};
`else
      T_SINT32: operand = {{32{value[31]}}, value[31:0]};
      T_SINT64: operand = value;
`endif
      default: begin
        bad_type  = 1'b1;
        is_varint = 1'b0;
      end
    endcase
  end

  // Varint encoders: length = highest non-zero 7-bit group, minimum one byte.
  always_comb begin
    key_word  = {field_id, wire_type};
    kshift    = '0;
    hdr_len_c = 3'd1;
    hdr_c     = '0;
    for (int unsigned i = 1; i < 5; i++)
      if ((key_word >> (7 * i)) != 32'd0) hdr_len_c = 3'(i + 1);
    for (int unsigned i = 0; i < 5; i++) begin
      kshift = key_word >> (7 * i);
      if (i < 32'(hdr_len_c))
        hdr_c[8*i +: 8] = {(i + 1 < 32'(hdr_len_c)), kshift[6:0]};
    end

    vshift = '0;
    if (is_varint) begin
      val_len_c = 4'd1;
      val_c     = '0;
      for (int unsigned i = 1; i < 10; i++)
        if ((operand >> (7 * i)) != 64'd0) val_len_c = 4'(i + 1);
      for (int unsigned i = 0; i < 10; i++) begin
        vshift = operand >> (7 * i);
        if (i < 32'(val_len_c))
          val_c[8*i +: 8] = {(i + 1 < 32'(val_len_c)), vshift[6:0]};
      end
    end else begin
      val_c     = fix_val;
      val_len_c = fix_len;
    end

    entry_err = bad_type || (field_id == 29'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      hdr_out   <= '0;
      hdr_len   <= '0;
      val_out   <= '0;
      val_len   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        err <= entry_err;
        if (entry_err) begin
          hdr_out <= '0;
          hdr_len <= '0;
          val_out <= '0;
          val_len <= '0;
        end else begin
          hdr_out <= hdr_c;
          hdr_len <= hdr_len_c;
          val_out <= val_c;
          val_len <= val_len_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_field_encoder.sv
// Directed bench for pb_field_encoder; expectations follow SER_ZIGZAG_EN when defined.
module tb_pb_field_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [28:0] field_id;
  logic [4:0]  field_type;
  logic [63:0] value;
  logic        out_valid;
  logic [39:0] hdr_out;
  logic [2:0]  hdr_len;
  logic [79:0] val_out;
  logic [3:0]  val_len;
  logic        err;

  logic [128:0] obs;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [28:0]  fid;
    logic [4:0]   typ;
    logic [63:0]  val;
    logic [128:0] exp;
    string        name;
  } vec_t;

  always #5 clk = ~clk;

  pb_field_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .field_id  (field_id),
    .field_type(field_type),
    .value     (value),
    .out_valid (out_valid),
    .hdr_out   (hdr_out),
    .hdr_len   (hdr_len),
    .val_out   (val_out),
    .val_len   (val_len),
    .err       (err)
  );

  assign obs = {out_valid, err, hdr_len, hdr_out, val_len, val_out};

  function automatic logic [128:0] exp_ok(input logic [39:0] h, input logic [2:0] hl,
                                          input logic [79:0] v, input logic [3:0] vl);
    return {1'b1, 1'b0, hl, h, vl, v};
  endfunction

  function automatic logic [128:0] exp_err();
    return {1'b1, 1'b1, 127'd0};
  endfunction

  task automatic drive(input logic [28:0] fid, input logic [4:0] typ, input logic [63:0] val);
    @(negedge clk);
    field_id   = fid;
    field_type = typ;
    value      = val;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    field_id = '0; field_type = '0; value = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 129'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 129'd0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_uint64_latency();
    drive(29'd1, 5'd4, 64'd150);
    n_checks++;
    if (obs !== exp_ok(40'h08, 3'd1, 80'h0196, 4'd2)) begin
      n_fail++;
      $display("FAIL uint64_150: got %h expected %h", obs, exp_ok(40'h08, 3'd1, 80'h0196, 4'd2));
    end
    idle_cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_valid_pulse: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_string_key();
    drive(29'd16, 5'd9, 64'd3);
    n_checks++;
    if (obs !== exp_ok(40'h0182, 3'd2, 80'h03, 4'd1)) begin
      n_fail++;
      $display("FAIL string_len: got %h expected %h", obs, exp_ok(40'h0182, 3'd2, 80'h03, 4'd1));
    end
    idle_cycle();
  endtask

  task automatic test_int32_negative();
    drive(29'd2, 5'd5, 64'h0000_0000_FFFF_FFFF);
    n_checks++;
    if (obs !== exp_ok(40'h10, 3'd1, 80'h01FF_FFFF_FFFF_FFFF_FFFF, 4'd10)) begin
      n_fail++;
      $display("FAIL int32_neg: got %h expected %h", obs,
               exp_ok(40'h10, 3'd1, 80'h01FF_FFFF_FFFF_FFFF_FFFF, 4'd10));
    end
    idle_cycle();
  endtask

  task automatic test_zigzag();
    logic [128:0] e17, e18;
`ifdef SER_ZIGZAG_EN
    e17 = exp_ok(40'h18, 3'd1, 80'h01, 4'd1);
    e18 = exp_ok(40'h20, 3'd1, 80'h02, 4'd1);
`else
    e17 = exp_ok(40'h18, 3'd1, 80'h01FF_FFFF_FFFF_FFFF_FFFF, 4'd10);
    e18 = exp_ok(40'h20, 3'd1, 80'h01, 4'd1);
`endif
    drive(29'd3, 5'd17, 64'h0000_0000_FFFF_FFFF);
    n_checks++;
    if (obs !== e17) begin
      n_fail++;
      $display("FAIL sint32: got %h expected %h", obs, e17);
    end
    drive(29'd4, 5'd18, 64'd1);
    n_checks++;
    if (obs !== e18) begin
      n_fail++;
      $display("FAIL sint64: got %h expected %h", obs, e18);
    end
    idle_cycle();
  endtask

  task automatic test_fixed32_hold();
    drive(29'd5, 5'd7, 64'hAAAA_BBBB_1234_5678);
    n_checks++;
    if (obs !== exp_ok(40'h2D, 3'd1, 80'h1234_5678, 4'd4)) begin
      n_fail++;
      $display("FAIL fixed32: got %h expected %h", obs, exp_ok(40'h2D, 3'd1, 80'h1234_5678, 4'd4));
    end
    @(negedge clk);
    in_valid = 1'b0;
    field_id = 29'd99; field_type = 5'd4; value = 64'd7;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b0, 3'd1, 40'h2D, 4'd4, 80'h1234_5678}) begin
      n_fail++;
      $display("FAIL hold_idle: got %h expected %h", obs,
               {1'b0, 1'b0, 3'd1, 40'h2D, 4'd4, 80'h1234_5678});
    end
  endtask

  task automatic test_back_to_back();
    vec_t vecs[10];
    vecs[0] = '{29'h1FFF_FFFF, 5'd1, 64'h0102_0304_0506_0708,
                exp_ok(40'h0F_FFFF_FFF9, 3'd5, 80'h0102_0304_0506_0708, 4'd8), "max_fid_double"};
    vecs[1] = '{29'd7, 5'd0, 64'd5, exp_err(), "type0_err"};
    vecs[2] = '{29'd0, 5'd4, 64'd5, exp_err(), "fid0_err"};
    vecs[3] = '{29'd7, 5'd19, 64'd5, exp_err(), "type19_err"};
    vecs[4] = '{29'd1, 5'd4, 64'd0, exp_ok(40'h08, 3'd1, 80'h00, 4'd1), "uint64_zero"};
    vecs[5] = '{29'd1, 5'd8, 64'hFE, exp_ok(40'h08, 3'd1, 80'h00, 4'd1), "bool_lsb"};
    vecs[6] = '{29'd1, 5'd13, 64'hFFFF_FFFF_0000_0080,
                exp_ok(40'h08, 3'd1, 80'h0180, 4'd2), "uint32_zext"};
    vecs[7] = '{29'd1, 5'd10, 64'h1234, exp_ok(40'h0B, 3'd1, 80'h0, 4'd0), "group"};
    vecs[8] = '{29'd15, 5'd16, 64'h8000_0000_0000_0001,
                exp_ok(40'h79, 3'd1, 80'h8000_0000_0000_0001, 4'd8), "sfixed64"};
    vecs[9] = '{29'd7, 5'd31, 64'd1, exp_err(), "type31_err"};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].fid, vecs[i].typ, vecs[i].val);
      n_checks++;
      if (obs !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL b2b_%s: got %h expected %h", vecs[i].name, obs, vecs[i].exp);
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_priority();
    drive(29'd1, 5'd4, 64'd150);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
    end
    // in_valid and reset together: sample is dropped
    @(negedge clk);
    field_id = 29'd16; field_type = 5'd9; value = 64'd3;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 129'd0) begin
      n_fail++;
      $display("FAIL reset_priority: got %h expected %h", obs, 129'd0);
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 129'd0) begin
      n_fail++;
      $display("FAIL reset_discard: got %h expected %h", obs, 129'd0);
    end
  endtask

  initial begin
    test_reset();
    test_uint64_latency();
    test_string_key();
    test_int32_negative();
    test_zigzag();
    test_fixed32_hold();
    test_back_to_back();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
